sprite_loader: RTL and testbench

Writes sprite pixel data into sprite memory. Sprite memory is laid out as address = {row[N2:0], col[N3:0]}. The block takes a valid/ready pixel stream from the ARMv4 memory-mapped I/O side and emits RAM write strobes in raster order (row-major, column fastest). It is the write-side counterpart of the renderer's pixel-to-address lookup, so the two must agree bit-for-bit on address layout.

---
 rtl/sprite_loader.sv | 166 ++++++++++++++++
 tb/tb_sprite_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_loader.sv
// ---------------------------------------------------------------------------
// sprite_loader
//
// Purpose:
//   Takes a valid/ready pixel stream from the memory-mapped I/O side and
//   turns it into sprite RAM write strobes in raster order (row-major,
//   column fastest). The RAM address is {row, col}. This layout must match
//   the renderer's pixel-to-address lookup bit for bit.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset; aborts any load in progress
//   start      single-cycle load request, honoured only while idle
//   width_m1   sprite width minus 1, latched when start is accepted
//   height_m1  sprite height minus 1, latched when start is accepted
//   s_valid    pixel word valid
//   s_data     pixel word
//   s_ready    loader accepts a pixel this cycle (depends on state only)
//   we         sprite RAM write enable (one cycle after the handshake)
//   waddr      sprite RAM address {row, col}, holds while we is low
//   wdata      sprite RAM write data, holds while we is low
//   busy       high from the accepted start until done
//   done       one-cycle pulse alongside the final pixel write
//
// Optional feature:
//   SPRITE_LOADER_TRANSPARENT_SKIP_EN - when defined, a pixel equal to
//   TRANSP still advances the raster position, but no RAM write is issued
//   for it. When undefined, every accepted pixel is written and TRANSP has
//   no effect.
// ---------------------------------------------------------------------------
module sprite_loader #(
    parameter int            N2     = 5,
    parameter int            N3     = 5,
    parameter int            DW     = 8,
    parameter logic [DW-1:0] TRANSP = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N3:0]       width_m1,
    input  logic [N2:0]       height_m1,
    input  logic              s_valid,
    input  logic [DW-1:0]     s_data,
    output logic              s_ready,
    output logic              we,
    output logic [N2+N3+1:0]  waddr,
    output logic [DW-1:0]     wdata,
    output logic              busy,
    output logic              done
);

`ifdef SPRITE_LOADER_TRANSPARENT_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [N3:0] col;
    logic [N3:0] width_lat;
    logic [N2:0] row;
    logic [N2:0] height_lat;

    logic handshake;
    logic last_pix;
    logic is_transp;
    logic write_pix;

    // The handshake is decoded straight from the state. It does not go
    // through s_ready, so the next-state logic below has no combinational
    // loop back into itself.
    assign handshake = s_valid && (state == LOAD);
    assign last_pix  = (col == width_lat) && (row == height_lat);
    assign is_transp = (s_data == TRANSP);
    // A transparent pixel is still consumed. Only its RAM write is dropped,
    // and only when skipping is built in.
    assign write_pix = handshake && !(SKIP_EN && is_transp);

    // State register. A reset in the middle of a load sends the block back
    // to IDLE with no done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs. FIN lasts exactly one cycle.
    // In FIN the registered write of the final pixel is on the RAM port,
    // so done is raised in that same cycle.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (handshake && last_pix) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Raster counters and the registered RAM write port. The dimensions are
    // latched only from IDLE, so a start that arrives mid-load cannot
    // disturb them. The column wraps on an equality compare against the
    // latched width, so a full-range width never overflows its field. The
    // address and data registers are loaded only when a write actually
    // happens. This makes them hold their last values while we is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            width_lat  <= '0;
            height_lat <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
        end else begin
            we <= write_pix;
            if ((state == IDLE) && start) begin
                width_lat  <= width_m1;
                height_lat <= height_m1;
                col        <= '0;
                row        <= '0;
            end else if (handshake) begin
                if (col == width_lat) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (write_pix) begin
                waddr <= {row, col};
                wdata <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_loader.sv
// ---------------------------------------------------------------------------
// tb_sprite_loader
//
// Purpose:
//   Self-checking bench for sprite_loader with the default parameters.
//   A behavioural model computes, cycle by cycle, what the loader should
//   show on its outputs. The raster position of each accepted pixel comes
//   from its index: row = index / width and col = index % width. The RAM
//   address is then row * 2^(N3+1) + col. The stimulus combines directed
//   loads with randomized ones; the randomized loads use a random s_valid
//   pattern and sometimes pulse start in the middle of a load.
//
// Optional feature:
//   SPRITE_LOADER_TRANSPARENT_SKIP_EN - when defined, the model suppresses
//   writes of TRANSP pixels, and a dedicated transparent-pixel load is run.
// ---------------------------------------------------------------------------
module tb_sprite_loader;

    localparam int          N2     = 5;
    localparam int          N3     = 5;
    localparam int          DW     = 8;
    localparam int          AW     = N2 + N3 + 2;
    localparam logic [7:0]  TRANSP = 8'hFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N3:0]   width_m1;
    logic [N2:0]   height_m1;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;

    sprite_loader #(
        .N2     (N2),
        .N3     (N3),
        .DW     (DW),
        .TRANSP (TRANSP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .width_m1  (width_m1),
        .height_m1 (height_m1),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_LOAD, M_FIN} mstate_t;

    int      checkCount = 0;
    int      passCount  = 0;

    mstate_t mState = M_IDLE;
    int      mW = 0;
    int      mCount = 0;
    int      mTotal = 0;
    logic    expWe = 1'b0;
    logic    expDone = 1'b0;
    int      expAddr = 0;
    int      expData = 0;
    int      wrSeen = 0;
    int      wrExp = 0;

    // Every comparison goes through here. A mismatch prints one FAIL line.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Call this at a falling edge. It drives one cycle of inputs, advances
    // the model across the next rising edge, and then, at the following
    // falling edge, compares the DUT outputs with the model.
    task automatic applyStimulus(input logic rst_i, input logic start_i,
                                 input int w_i, input int h_i,
                                 input logic valid_i, input int data_i);
        int r;
        int c;
        logic writeIt;
        rst       = rst_i;
        start     = start_i;
        width_m1  = w_i[N3:0];
        height_m1 = h_i[N2:0];
        s_valid   = valid_i;
        s_data    = data_i[DW-1:0];
        #1;
        checkOutput("s_ready", {31'd0, s_ready}, {31'd0, mState == M_LOAD});

        expWe = 1'b0;
        if (rst_i) begin
            mState  = M_IDLE;
            expAddr = 0;
            expData = 0;
        end else begin
            case (mState)
                M_IDLE: begin
                    if (start_i) begin
                        mW     = w_i;
                        mCount = 0;
                        mTotal = (w_i + 1) * (h_i + 1);
                        mState = M_LOAD;
                    end
                end
                M_LOAD: begin
                    if (valid_i) begin
                        r = mCount / (mW + 1);
                        c = mCount % (mW + 1);
                        writeIt = 1'b1;
`ifdef SPRITE_LOADER_TRANSPARENT_SKIP_EN
                        if (data_i[7:0] == TRANSP) writeIt = 1'b0;
`endif
                        if (writeIt) begin
                            expWe   = 1'b1;
                            expAddr = r * (1 << (N3 + 1)) + c;
                            expData = data_i & 8'hFF;
                            wrExp++;
                        end
                        mCount++;
                        if (mCount == mTotal) mState = M_FIN;
                    end
                end
                default: begin
                    mState = M_IDLE;
                end
            endcase
        end
        expDone = (mState == M_FIN);

        @(posedge clk);
        @(negedge clk);
        checkOutput("we",    {31'd0, we},   {31'd0, expWe});
        checkOutput("done",  {31'd0, done}, {31'd0, expDone});
        checkOutput("busy",  {31'd0, busy}, {31'd0, mState != M_IDLE});
        checkOutput("waddr", {20'd0, waddr}, expAddr);
        checkOutput("wdata", {24'd0, wdata}, expData);
        if (we) wrSeen++;
    endtask

    // Runs one complete load with the given dimensions. Each cycle s_valid
    // is random, the data is random and leans towards TRANSP, and start is
    // sometimes pulsed with other dimensions, which the loader must ignore.
    task automatic runLoad(input int w, input int h, input int validPct);
        logic v;
        logic st;
        int   d;
        wrSeen = 0;
        wrExp  = 0;
        applyStimulus(1'b0, 1'b1, w, h, 1'b0, 0);
        for (int k = 0; k < 20000 && mState != M_IDLE; k++) begin
            v  = ($urandom_range(99) < validPct);
            st = ($urandom_range(9) == 0);
            d  = ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255));
            applyStimulus(1'b0, st, int'($urandom_range(63)), int'($urandom_range(63)), v, d);
        end
        checkOutput("write_count", wrSeen, wrExp);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        width_m1  = '0;
        height_m1 = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then one idle cycle.
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);

        // 2x2 load with s_valid held high and data 1..4.
        wrSeen = 0;
        applyStimulus(1'b0, 1'b1, 1, 1, 1'b0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, i);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
        checkOutput("2x2_writes", wrSeen, 4);

        // Full-range 64x64 load.
        runLoad(63, 63, 100);

        // 3x1 load with s_valid toggling 1,0,1,0,1.
        wrSeen = 0;
        applyStimulus(1'b0, 1'b1, 2, 0, 1'b0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 0, 0, (i % 2) == 0, 10 + i);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
        checkOutput("3x1_writes", wrSeen, 3);

        // start pulsed during LOAD with different dimensions.
        wrSeen = 0;
        applyStimulus(1'b0, 1'b1, 1, 1, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 20);
        applyStimulus(1'b0, 1'b1, 7, 7, 1'b1, 21);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 22);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 23);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
        checkOutput("restart_ignored_writes", wrSeen, 4);

        // Reset after 2 of 4 pixels, then a fresh load from address 0.
        applyStimulus(1'b0, 1'b1, 1, 1, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 40);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 41);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 42);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 43);
        runLoad(1, 1, 100);

`ifdef SPRITE_LOADER_TRANSPARENT_SKIP_EN
        // Transparent pixels advance the raster position but are not written.
        wrSeen = 0;
        applyStimulus(1'b0, 1'b1, 1, 1, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 255);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 7);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 255);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
        checkOutput("transp_writes", wrSeen, 2);
`endif

        // Single-pixel load and several random-sized loads.
        runLoad(0, 0, 50);
        for (int n = 0; n < 8; n++) begin
            runLoad(int'($urandom_range(7)), int'($urandom_range(7)), 30 + int'($urandom_range(70)));
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
